// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised clock-enabled register file.
package rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int RF_WIDTH_DEFAULT = 16;
    localparam int RF_DEPTH_DEFAULT = 8;

    // Address width; never below 1 so a 2-entry file still has an address bit.
    function automatic int rf_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rf_param_clken_if.sv
// Write/read bus of the register file; master drives requests, slave returns data.
interface rf_param_clken_if
    import rf_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH_DEFAULT,
    parameter int DEPTH = RF_DEPTH_DEFAULT
) ();
    localparam int AW = rf_clog2(DEPTH);

    logic             ce;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] qa;
    logic [WIDTH-1:0] qb;
    logic             busy;

    modport master (
        output ce, we, waddr, wdata, raddr_a, raddr_b,
        input  qa, qb, busy
    );

    modport slave (
        input  ce, we, waddr, wdata, raddr_a, raddr_b,
        output qa, qb, busy
    );
endinterface

// File: rtl/rf_read_port.sv
// One registered read port: write-first bypass, out-of-range zeroing, clock enable.
module rf_read_port #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk_n,
    input  logic             rst,
    input  logic             ce,
    input  logic             clear,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] q
);
    logic             in_range;
    logic [WIDTH-1:0] q_reg;

    assign in_range = (32'(raddr) < DEPTH);

    always_ff @(posedge clk_n) begin
        if (rst) begin
            q_reg <= '0;
        end else if (ce) begin
            if (clear || !in_range) begin
                q_reg <= '0;
            end else if (we && (waddr == raddr)) begin
                q_reg <= wdata;
            end else begin
                q_reg <= rdata;
            end
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/rf_param_clken.sv
// DEPTH x WIDTH register file, one write and two read ports, with a
// post-reset hardware sweep that zeroes every entry before writes are accepted.
module rf_param_clken
    import rf_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH_DEFAULT,
    parameter int DEPTH = RF_DEPTH_DEFAULT
) (
    input  logic clk_n,
    input  logic rst,
    rf_param_clken_if.slave bus
);
    localparam int AW = rf_clog2(DEPTH);

    rf_state_e        state_reg;
    logic [AW-1:0]    cnt_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             clear;
    logic             wr_in_range;
    logic [AW-1:0]    raddr [2];
    logic [WIDTH-1:0] q [2];

    assign clear       = (state_reg == CLEAR);
    assign wr_in_range = (32'(bus.waddr) < DEPTH);
    assign bus.busy    = clear;

    always_ff @(posedge clk_n) begin
        if (rst) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else if (bus.ce) begin
            case (state_reg)
                CLEAR: begin
                    if (32'(cnt_reg) == DEPTH - 1) begin
                        state_reg <= READY;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + AW'(1);
                    end
                end
                READY: state_reg <= READY;
                default: state_reg <= CLEAR;
            endcase
        end
    end

    // Storage has no reset so it maps onto RAM; the sweep provides the zeroing.
    always_ff @(posedge clk_n) begin
        if (!rst && bus.ce) begin
            if (clear) begin
                mem[cnt_reg] <= '0;
            end else if (bus.we && wr_in_range) begin
                mem[bus.waddr] <= bus.wdata;
            end
        end
    end

    assign raddr[0] = bus.raddr_a;
    assign raddr[1] = bus.raddr_b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        rf_read_port #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_port (
            .clk_n (clk_n),
            .rst   (rst),
            .ce    (bus.ce),
            .clear (clear),
            .we    (bus.we),
            .waddr (bus.waddr),
            .wdata (bus.wdata),
            .raddr (raddr[gi]),
            .rdata (mem[raddr[gi]]),
            .q     (q[gi])
        );
    end

    assign bus.qa = q[0];
    assign bus.qb = q[1];
endmodule

// File: tb/tb_rf_param_clken.sv
// Drives an 8x16 and a 5x8 instance with the same stimulus and checks both
// against a behavioural register-file model every cycle.
module tb_rf_param_clken;

    logic clk_n = 1'b0;
    always #5 clk_n = ~clk_n;

    logic        rst;
    logic        ce;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;

    int tests = 0;
    int fails = 0;

    rf_param_clken_if #(.WIDTH(16), .DEPTH(8)) bus8 ();
    rf_param_clken_if #(.WIDTH(8),  .DEPTH(5)) bus5 ();

    assign bus8.ce      = ce;
    assign bus8.we      = we;
    assign bus8.waddr   = waddr;
    assign bus8.wdata   = wdata;
    assign bus8.raddr_a = raddr_a;
    assign bus8.raddr_b = raddr_b;
    assign bus5.ce      = ce;
    assign bus5.we      = we;
    assign bus5.waddr   = waddr;
    assign bus5.wdata   = wdata[7:0];
    assign bus5.raddr_a = raddr_a;
    assign bus5.raddr_b = raddr_b;

    rf_param_clken #(.WIDTH(16), .DEPTH(8)) dut8 (
        .clk_n (clk_n),
        .rst   (rst),
        .bus   (bus8.slave)
    );

    rf_param_clken #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clk_n (clk_n),
        .rst   (rst),
        .bus   (bus5.slave)
    );

    // Behavioural model: index 0 is the 8x16 file, index 1 the 5x8 file.
    logic [15:0] m_mem [2][8];
    int          pend [2];
    logic [15:0] e_qa [2];
    logic [15:0] e_qb [2];
    int          dep [2] = '{8, 5};
    logic [15:0] msk [2] = '{16'hFFFF, 16'h00FF};
    bit          m_valid = 1'b0;

    function automatic logic [15:0] m_read(input int k, input logic [2:0] a);
        if (int'(a) >= dep[k]) return 16'h0000;
        if (we && waddr == a) return wdata & msk[k];
        return m_mem[k][a];
    endfunction

    initial forever begin
        @(posedge clk_n);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                pend[k] = dep[k];
                e_qa[k] = 16'h0000;
                e_qb[k] = 16'h0000;
            end else if (ce) begin
                if (pend[k] > 0) begin
                    m_mem[k][dep[k] - pend[k]] = 16'h0000;
                    pend[k] = pend[k] - 1;
                    e_qa[k] = 16'h0000;
                    e_qb[k] = 16'h0000;
                end else begin
                    e_qa[k] = m_read(k, raddr_a);
                    e_qb[k] = m_read(k, raddr_b);
                    if (we && int'(waddr) < dep[k]) m_mem[k][waddr] = wdata & msk[k];
                end
            end
        end
        if (rst) m_valid = 1'b1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk_n);
        if (m_valid) begin
            chk("model_qa8",   bus8.qa, e_qa[0]);
            chk("model_qb8",   bus8.qb, e_qb[0]);
            chk("model_busy8", {15'b0, bus8.busy}, 16'(pend[0] > 0));
            chk("model_qa5",   {8'h00, bus5.qa}, e_qa[1]);
            chk("model_qb5",   {8'h00, bus5.qb}, e_qb[1]);
            chk("model_busy5", {15'b0, bus5.busy}, 16'(pend[1] > 0));
        end
    end

    task automatic cyc(input logic r, input logic c, input logic w, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [2:0] ra, input logic [2:0] rb);
        rst = r; ce = c; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
        @(posedge clk_n);
        @(negedge clk_n);
    endtask

    logic [7:0] tbl5 [4] = '{8'h11, 8'h22, 8'h44, 8'h88};

    initial begin
        rst = 1'b1; ce = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        @(negedge clk_n);
        cyc(1, 1, 0, 0, 16'h0, 0, 0);
        cyc(1, 1, 0, 0, 16'h0, 0, 0);
        chk("rst_qa8",   bus8.qa, 16'h0000);
        chk("rst_qb8",   bus8.qb, 16'h0000);
        chk("rst_busy8", {15'b0, bus8.busy}, 16'h0001);

        // Sweep length, with a write attempted on the first sweep edge.
        for (int i = 1; i <= 8; i++) begin
            if (i == 1) cyc(0, 1, 1, 3, 16'hAAAA, 0, 0);
            else        cyc(0, 1, 0, 0, 16'h0, 0, 0);
            chk("sweep_busy8", {15'b0, bus8.busy}, 16'(i < 8));
            chk("sweep_busy5", {15'b0, bus5.busy}, 16'(i < 5));
        end
        cyc(0, 1, 0, 0, 16'h0, 3, 3);
        chk("sweep_nowrite8", bus8.qa, 16'h0000);

        cyc(0, 1, 1, 0, 16'h1111, 0, 0);
        cyc(0, 1, 1, 1, 16'h2222, 0, 0);
        cyc(0, 1, 1, 2, 16'h4444, 0, 0);
        cyc(0, 1, 1, 3, 16'h8888, 0, 0);
        cyc(0, 1, 0, 0, 16'h0, 2, 3);
        chk("rd_qa8", bus8.qa, 16'h4444);
        chk("rd_qb8", bus8.qb, 16'h8888);
        chk("rd_qa5", {8'h00, bus5.qa}, 16'h0044);
        chk("pin_model_qb8", e_qb[0], 16'h8888);

        cyc(0, 1, 1, 5, 16'hCCCC, 5, 5);
        chk("byp_qa8", bus8.qa, 16'hCCCC);
        chk("byp_qb8", bus8.qb, 16'hCCCC);
        chk("byp_oor_qa5", {8'h00, bus5.qa}, 16'h0000);
        cyc(0, 1, 0, 0, 16'h0, 5, 5);
        chk("byp_after_qa8", bus8.qa, 16'hCCCC);

        cyc(0, 1, 0, 0, 16'h0, 2, 2);
        cyc(0, 0, 1, 2, 16'hFFFF, 0, 0);
        chk("ce_hold_qa8", bus8.qa, 16'h4444);
        cyc(0, 1, 0, 0, 16'h0, 2, 2);
        chk("ce_nowrite_qa8", bus8.qa, 16'h4444);

        cyc(0, 1, 1, 6, 16'h005A, 0, 0);
        cyc(0, 1, 0, 0, 16'h0, 6, 4);
        chk("oor_rd_qa5", {8'h00, bus5.qa}, 16'h0000);
        chk("oor_e4_qb5", {8'h00, bus5.qb}, 16'h0000);
        chk("oor_wr_qa8", bus8.qa, 16'h005A);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 16'h0, 3'(i), 3'(i));
            chk("oor_keep_qa5", {8'h00, bus5.qa}, {8'h00, tbl5[i]});
        end

        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 3'(i), 16'hFFFF, 0, 0);
        cyc(0, 1, 0, 0, 16'h0, 1, 2);
        chk("fill_qa8", bus8.qa, 16'hFFFF);
        cyc(1, 1, 0, 0, 16'h0, 1, 2);
        chk("rst2_qa8", bus8.qa, 16'h0000);
        chk("rst2_qb8", bus8.qb, 16'h0000);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 16'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 16'h1234, 0, 0);
            chk("pause_busy8", {15'b0, bus8.busy}, 16'h0001);
        end
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 1, 0, 0, 16'h0, 0, 0);
            chk("resume_busy8", {15'b0, bus8.busy}, 16'(i < 5));
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 0, 16'h0, 3'(i), 3'(7 - i));
            chk("cleared_qa8", bus8.qa, 16'h0000);
            chk("cleared_qb8", bus8.qb, 16'h0000);
        end

        // Randomised traffic, checked by the every-cycle compare process.
        repeat (3000) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_param_clken.md
# rf_param_clken

Parametrised register file with clock enable: a generalised successor to the fixed 16-bit clock-enabled register. It provides DEPTH words of WIDTH bits, one write port and two independent registered read ports, with write-first bypass. A hardware clear sweep zeroes every entry after reset. It sits in the datapath wherever the single 16-bit register was used, and also serves as a small operand register file.

## Interface
- WIDTH, 16: data width in bits, ≥1.
- DEPTH, 8: number of entries, ≥2; power of two not required.
- AW (localparam), clog2(DEPTH): address width.
- clk_n  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when 0, all state holds (except under rst).
- we  in  1  write enable, qualified by ce.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr_a  in  AW  read address, port A.
- raddr_b  in  AW  read address, port B.
- qa  out  WIDTH  registered read data, port A.
- qb  out  WIDTH  registered read data, port B.
- busy  out  1  high while the clear sweep is running; writes are ignored.

## Operation
- FSM has two states: CLEAR and READY. Reset state is CLEAR with sweep counter cnt=0.
- rst=1, which overrides ce:
  - state←CLEAR, cnt←0, qa←0, qb←0, busy=1.
  - Array contents are not modified in this cycle.
- CLEAR with ce=1:
  - entry[cnt]←0 and cnt←cnt+1.
  - When cnt=DEPTH-1, the next state is READY.
  - The sweep takes exactly DEPTH enabled cycles.
  - we is ignored. qa and qb are loaded with 0.
- CLEAR with ce=0: hold. The sweep pauses.
- READY with ce=1:
  - If we=1 and waddr<DEPTH: entry[waddr]←wdata.
  - qa←(we && waddr==raddr_a) ? wdata : entry[raddr_a]. This is write-first bypass.
  - qb follows the same rule with raddr_b.
- READY with ce=0:
  - No write occurs. qa and qb hold their previous values.
  - Address and data changes have no effect.
- Out-of-range address (≥DEPTH, only possible when DEPTH is not a power of two):
  - A write is dropped.
  - A read loads 0 into qa/qb. Bypass does not apply.
- Both read ports may address the same entry, and may address the write target, in the same cycle. Each port resolves independently.
- busy is a combinational decode of state: 1 in CLEAR, 0 in READY.
- Reset asserted mid-sweep or in READY restarts the sweep from entry 0. Reset in READY discards contents once the sweep completes.

## Timing
- Read latency is 1 cycle. Address presented at enabled edge k gives data on qa/qb after edge k.
- Write-to-read through the array is 1 cycle. The same-cycle collision returns new data via the bypass.
- After rst falls, busy=1 for exactly DEPTH enabled edges. busy drops after the edge that clears entry DEPTH-1.
- The first accepted write happens on the first enabled edge with busy=0.
- Reset values: qa=0, qb=0, busy=1.
- Combinational paths: none from inputs to outputs. busy depends only on state.

## Structure
- Shared package rf_pkg holds:
  - the state enum (CLEAR, READY);
  - a clog2 function, or the AW computation;
  - default WIDTH/DEPTH constants used by integrating tops.
- One sub-module is natural: rf_read_port (address compare, bypass mux, out-of-range zeroing, output register with ce), instantiated twice.
- The FSM, sweep counter and storage array live in the top.

## Test plan
- Reset sweep: rst=1 for 2 cycles, then rst=0, ce=1, DEPTH=8. Required: busy=1 for exactly 8 edges, then 0. A write of 16'hAAAA to address 3 during the sweep is not stored; reading address 3 afterwards gives 16'h0000.
- Basic write/read:
  - Write 16'h1111, 16'h2222, 16'h4444, 16'h8888 to addresses 0–3 on consecutive cycles.
  - Then raddr_a=2, raddr_b=3. Required: qa=16'h4444 and qb=16'h8888 one edge later.
- Bypass: we=1, waddr=5, wdata=16'hCCCC, raddr_a=raddr_b=5 in the same cycle. Required: qa=qb=16'hCCCC after that edge. The next cycle with we=0 still reads 16'hCCCC.
- Clock enable:
  - With qa=16'h4444, drop ce and write 16'hFFFF to address 2 with raddr_a=0.
  - Required: qa remains 16'h4444 and entry 2 is unchanged (reads 16'h4444 after ce returns).
  - With ce=0 during the sweep, busy stays 1 and the sweep resumes where it paused.
- Reset mid-operation: fill entries with 16'hFFFF, then assert rst for 1 cycle. Required: qa=qb=0 immediately, the full DEPTH-cycle sweep reruns, and all entries read 0.
- Non-power-of-two: DEPTH=5, WIDTH=8, write 8'h5A to address 6. Required: the write is dropped, reading address 6 gives 8'h00, and entries 0–4 are unchanged.
